niosv_timer_sched: RTL and testbench

Hardware scheduler that shares the single system interval timer among NREQ requesters, each asking for a one-shot delay of a given tick count. It sits between requesting logic and the timer's 16-bit register slave. It grants requesters round-robin, programs period and control through an Avalon-MM write-only master, waits on the timer irq, clears the timeout status, and pulses the winner's done line. Only one delay is in flight at a time.

---
 rtl/niosv_timer_sched.sv | 146 ++++++++++++++
 tb/tb_niosv_timer_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosv_timer_sched.sv
// Round-robin scheduler sharing one interval timer among NREQ one-shot delay requesters.
// Programs the timer over a write-only Avalon-MM master and pulses the winner's done line.
module niosv_timer_sched #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_ticks,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 m_chipselect,
  output logic                 m_write_n,
  output logic [2:0]           m_address,
  output logic [15:0]          m_writedata,
  input  logic                 t_irq
);

  localparam int unsigned NR = NREQ;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STOP  = 3'd1;
  localparam logic [2:0] S_PERL  = 3'd2;
  localparam logic [2:0] S_PERH  = 3'd3;
  localparam logic [2:0] S_START = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_CLEAR = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]  state;
  logic        abort;
  logic [31:0] ticks;
  logic [2:0]  gid;
  logic [2:0]  last;

  logic        found;
  logic [2:0]  pick;
  logic [31:0] pick_ticks;
  int unsigned rr_idx;
  logic        req_sel;

  // Round-robin search starting one past the last completed grant.
  always_comb begin
    found      = 1'b0;
    pick       = '0;
    pick_ticks = '0;
    rr_idx     = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      rr_idx = (32'(last) + i + 1) % NR;
      if (!found && req[rr_idx[IW-1:0]]) begin
        found      = 1'b1;
        pick       = rr_idx[2:0];
        pick_ticks = req_ticks[32*rr_idx +: 32];
      end
    end
  end

  assign req_sel = req[gid[IW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      abort <= 1'b0;
      ticks <= '0;
      gid   <= '0;
      last  <= 3'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            gid   <= pick;
            ticks <= pick_ticks;
            abort <= 1'b0;
            state <= (pick_ticks == '0) ? S_DONE : S_STOP;
          end
        end
        // The abort write shares the STOP encoding; the flag steers it straight to CLEAR.
        S_STOP:  state <= abort ? S_CLEAR : S_PERL;
        S_PERL:  state <= S_PERH;
        S_PERH:  state <= S_START;
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (t_irq) begin
            state <= S_CLEAR;
          end else if (!req_sel) begin
            abort <= 1'b1;
            state <= S_STOP;
          end
        end
        S_CLEAR: state <= abort ? S_IDLE : S_DONE;
        S_DONE: begin
          last  <= gid;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = '0;
    m_writedata  = '0;
    case (state)
      S_STOP: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd1;
        m_writedata  = 16'h0008;
      end
      S_PERL: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd2;
        m_writedata  = ticks[15:0];
      end
      S_PERH: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd3;
        m_writedata  = ticks[31:16];
      end
      S_START: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd1;
        m_writedata  = 16'h0005;
      end
      S_CLEAR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd0;
        m_writedata  = 16'h0000;
      end
      default: ;
    endcase
  end

  assign done     = (state == S_DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << gid) : '0;
  assign busy     = (state != S_IDLE);
  assign grant_id = gid;

endmodule

// File: tb/tb_niosv_timer_sched.sv
// Directed bench for niosv_timer_sched with a small behavioural interval-timer model.
module tb_niosv_timer_sched;

  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [32*NREQ-1:0]  req_ticks = '0;
  logic [NREQ-1:0]     done;
  logic                busy;
  logic [2:0]          grant_id;
  logic                m_chipselect;
  logic                m_write_n;
  logic [2:0]          m_address;
  logic [15:0]         m_writedata;
  logic                t_irq = 1'b0;

  niosv_timer_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_ticks(req_ticks),
    .done(done), .busy(busy), .grant_id(grant_id),
    .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_address(m_address), .m_writedata(m_writedata), .t_irq(t_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Timer model: period registers, one-shot down counter, sticky irq cleared by a status write.
  logic [15:0] per_l = '0, per_h = '0;
  logic [31:0] cnt = '0;
  logic        running = 1'b0, ito = 1'b0;
  int          irq_cyc = -1;
  logic [18:0] wq[$];
  int          wc[$];

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      ito     <= 1'b0;
      t_irq   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (running) begin
        if (cnt == 0) begin
          running <= 1'b0;
          if (ito) begin
            t_irq   <= 1'b1;
            irq_cyc <= cyc;
          end
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (m_chipselect && !m_write_n) begin
        wq.push_back({m_address, m_writedata});
        wc.push_back(cyc);
        case (m_address)
          3'd0: t_irq <= 1'b0;
          3'd1: begin
            ito <= m_writedata[0];
            if (m_writedata[3]) running <= 1'b0;
            if (m_writedata[2]) begin
              running <= 1'b1;
              cnt     <= {per_h, per_l};
            end
          end
          3'd2: per_l <= m_writedata;
          3'd3: per_h <= m_writedata;
          default: ;
        endcase
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] t);
    req[i] = v;
    req_ticks[32*i +: 32] = t;
  endtask

  task automatic wait_done(input int i, input int budget, output int dc, output bit ok);
    ok = 1'b0;
    dc = -1;
    for (int n = 0; n < budget && !ok; n++) begin
      step();
      if (done[i]) begin
        ok = 1'b1;
        dc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({done, busy, grant_id, m_chipselect, m_write_n, m_address, m_writedata} !==
        {4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: got done=%b busy=%b gid=%0d cs=%b wn=%b a=%0d d=%h, required 0 0 0 0 1 0 0000",
               done, busy, grant_id, m_chipselect, m_write_n, m_address, m_writedata);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_all_four();
    int order[$];
    bit multi;
    multi = 1'b0;
    wq.delete(); wc.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'(3 + i));
    for (int n = 0; n < 400 && order.size() < 4; n++) begin
      step();
      if ($countones(done) > 1) multi = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (done[i]) begin
          order.push_back(i);
          req[i] = 1'b0;
        end
    end
    checks++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
      errors++;
      $display("FAIL all_four_order: got %0d completions %p, required 0,1,2,3", order.size(), order);
    end
    checks++;
    if (multi !== 1'b0) begin
      errors++;
      $display("FAIL done_onehot: got multi-bit done, required one-hot");
    end
    checks++;
    if (wq.size() != 20) begin
      errors++;
      $display("FAIL all_four_writes: got %0d writes, required 20", wq.size());
    end
    order.delete();
    step();
    set_req(1, 1'b1, 32'd4);
    set_req(3, 1'b1, 32'd4);
    for (int n = 0; n < 200 && order.size() < 2; n++) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (done[i]) begin
          order.push_back(i);
          req[i] = 1'b0;
        end
    end
    checks++;
    if (order.size() != 2 || order[0] != 1 || order[1] != 3) begin
      errors++;
      $display("FAIL rr_reraise_order: got %p, required 1,3", order);
    end
    step();
  endtask

  task automatic test_single();
    int t0, dc;
    bit ok;
    logic [18:0] exp_w[5];
    exp_w[0] = {3'd1, 16'h0008};
    exp_w[1] = {3'd2, 16'h000A};
    exp_w[2] = {3'd3, 16'h0000};
    exp_w[3] = {3'd1, 16'h0005};
    exp_w[4] = {3'd0, 16'h0000};
    wq.delete(); wc.delete();
    t0 = cyc;
    set_req(0, 1'b1, 32'd10);
    for (int n = 0; n < 6; n++) step();
    checks++;
    if (busy !== 1'b1 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL single_busy: got busy=%b gid=%0d, required busy=1 gid=0", busy, grant_id);
    end
    wait_done(0, 100, dc, ok);
    req[0] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_done_timeout: got no done[0], required a pulse");
    end
    checks++;
    if (wq.size() != 5) begin
      errors++;
      $display("FAIL single_write_count: got %0d, required 5", wq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (wq[k] !== exp_w[k]) begin
          errors++;
          $display("FAIL single_write%0d: got a=%0d d=%h, required a=%0d d=%h",
                   k, wq[k][18:16], wq[k][15:0], exp_w[k][18:16], exp_w[k][15:0]);
        end
      end
      checks++;
      if (wc[0] != t0 + 1 || wc[3] != t0 + 4) begin
        errors++;
        $display("FAIL single_latency: got stop@%0d start@%0d, required %0d %0d", wc[0], wc[3], t0 + 1, t0 + 4);
      end
      checks++;
      if (wc[4] != irq_cyc + 1 || dc != irq_cyc + 2) begin
        errors++;
        $display("FAIL irq_to_done: got clear@%0d done@%0d, required %0d %0d", wc[4], dc, irq_cyc + 1, irq_cyc + 2);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: got busy=%b done=%b, required 0 0000", busy, done);
    end
  endtask

  task automatic test_wide();
    int c;
    wq.delete(); wc.delete();
    set_req(1, 1'b1, 32'h0001_86A0);
    for (int n = 0; n < 5; n++) step();
    checks++;
    if (wq.size() != 4 || wq[1] !== {3'd2, 16'h86A0} || wq[2] !== {3'd3, 16'h0001}) begin
      errors++;
      $display("FAIL wide_period: got %0d writes pl=%h ph=%h, required 4 writes 86A0 0001",
               wq.size(), (wq.size() > 1) ? wq[1][15:0] : 16'hxxxx, (wq.size() > 2) ? wq[2][15:0] : 16'hxxxx);
    end
    c = cyc;
    req[1] = 1'b0;
    for (int n = 0; n < 3; n++) step();
    checks++;
    if (wq.size() != 6 || wq[4] !== {3'd1, 16'h0008} || wq[5] !== {3'd0, 16'h0000} ||
        wc[4] != c + 1 || wc[5] != c + 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wide_abort: got %0d writes busy=%b, required stop@%0d clear@%0d then idle",
               wq.size(), busy, c + 1, c + 2);
    end
  endtask

  task automatic test_zero();
    wq.delete(); wc.delete();
    set_req(2, 1'b1, 32'd0);
    step();
    checks++;
    if (done !== 4'b0100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b, required 0100 1", done, busy);
    end
    req[2] = 1'b0;
    step();
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0 || wq.size() != 0) begin
      errors++;
      $display("FAIL zero_nobus: got done=%b busy=%b writes=%0d, required 0000 0 0", done, busy, wq.size());
    end
  endtask

  task automatic test_cancel();
    int c;
    bit bad;
    bad = 1'b0;
    wq.delete(); wc.delete();
    set_req(1, 1'b1, 32'd1000);
    for (int n = 0; n < 55; n++) step();
    c = cyc;
    req[1] = 1'b0;
    for (int n = 0; n < 1100; n++) begin
      step();
      if (done !== 4'b0000 || t_irq !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (wq.size() != 6 || wq[4] !== {3'd1, 16'h0008} || wq[5] !== {3'd0, 16'h0000} ||
        wc[4] != c + 1 || wc[5] != c + 2) begin
      errors++;
      $display("FAIL cancel_writes: got %0d writes, required 6 with stop@%0d clear@%0d", wq.size(), c + 1, c + 2);
    end
    checks++;
    if (bad !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_quiet: got done/irq activity=%b busy=%b, required 0 0", bad, busy);
    end
  endtask

  task automatic test_irq_cancel_same();
    bit seen;
    seen = 1'b0;
    set_req(3, 1'b1, 32'd5);
    for (int n = 0; n < 100 && !seen; n++) begin
      step();
      if (t_irq === 1'b1) seen = 1'b1;
    end
    req[3] = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL same_irq_timeout: got no t_irq, required irq");
    end
    step();
    step();
    checks++;
    if (done !== 4'b1000) begin
      errors++;
      $display("FAIL irq_beats_cancel: got done=%b, required 1000", done);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    int dc;
    bit ok;
    set_req(0, 1'b1, 32'd20);
    for (int n = 0; n < 8; n++) step();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({done, busy, grant_id, m_chipselect, m_write_n, m_address, m_writedata} !==
        {4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL midreset_state: got done=%b busy=%b gid=%0d cs=%b wn=%b a=%0d d=%h, required 0 0 0 0 1 0 0000",
               done, busy, grant_id, m_chipselect, m_write_n, m_address, m_writedata);
    end
    step();
    wq.delete(); wc.delete();
    reset_n = 1'b1;
    for (int n = 0; n < 5; n++) step();
    checks++;
    if (wq.size() < 2 || wq[0] !== {3'd1, 16'h0008} || wq[1] !== {3'd2, 16'd20}) begin
      errors++;
      $display("FAIL midreset_restart: got %0d writes first=%h, required stop then period_l 0014",
               wq.size(), (wq.size() > 0) ? wq[0] : 19'h0);
    end
    wait_done(0, 100, dc, ok);
    req[0] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_done: got no done[0], required a pulse");
    end
    step();
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_wide();
    test_zero();
    test_cancel();
    test_irq_cancel_same();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
